// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch-queue types, constants and fetch state encoding
package fetch_queue_pkg;
  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam logic [63:0] FETCH_QUEUE_RESET_PC = 64'h0;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic fault;
  } fetch_entry_t;
  typedef enum logic {FQ_RUN, FQ_FAULT} fq_state_e;
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: entry-typed circular buffer with head/tail pointers, occupancy count and flush
// ports: clk_i, rst_i, flush_i (empties queue), push_i/din_i, pop_i/dout_o (zero when empty), count_o
module sync_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  T din_i,
  output T dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  T mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    head_d = flush_i ? '0 : head_q + AW'(pop_i);
    tail_d = flush_i ? '0 : tail_q + AW'(push_i);
    count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[tail_q] <= din_i;
  end
  assign dout_o = (count_q != '0) ? mem_q[head_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled fetch front end owning the fetch PC, buffering {pc, inst, fault} for decode
// ports: clk_i/rst_i; rom_addr_o -> CodeROM, rom_data_i/rom_fault_i same cycle; redirect_i/redirect_pc_i flush+restart;
// halt_i stops fetching; deq_valid_o/deq_ready_i + deq_pc_o/deq_inst_o/deq_fault_o head entry; count_o occupancy
// FETCH_QUEUE_BYPASS_EN: presents the ROM word directly on deq_* when the queue is empty and decode is ready
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = FETCH_QUEUE_RESET_PC
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic [DATA_WIDTH-1:0] rom_addr_o,
  input  logic [INST_WIDTH-1:0] rom_data_i,
  input  logic rom_fault_i,
  input  logic redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic halt_i,
  output logic deq_valid_o,
  input  logic deq_ready_i,
  output logic [DATA_WIDTH-1:0] deq_pc_o,
  output logic [INST_WIDTH-1:0] deq_inst_o,
  output logic deq_fault_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic fault;
  } entry_t;
  fq_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0] count;
  logic empty, fetch_ok, bypass, push, pop, fifo_push, fifo_pop;
  entry_t rom_e, head_e;
  always_comb begin
    rom_e = '{pc: pc_q, inst: rom_data_i, fault: rom_fault_i};
    empty = count == '0;
    fetch_ok = state_q == FQ_RUN && !halt_i && !redirect_i;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty && fetch_ok && deq_ready_i;
`else
    bypass = 1'b0;
`endif
    deq_valid_o = !redirect_i && (!empty || bypass);
    pop = deq_valid_o && deq_ready_i;
    push = fetch_ok && (count != CW'(DEPTH) || pop);
    fifo_push = push && !bypass;
    fifo_pop = pop && !bypass;
    {deq_pc_o, deq_inst_o, deq_fault_o} = bypass ? rom_e : head_e;
    pc_d = redirect_i ? redirect_pc_i : push ? pc_q + DATA_WIDTH'(4) : pc_q;
    state_d = redirect_i ? FQ_RUN : (push && rom_fault_i) ? FQ_FAULT : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
      state_q <= FQ_RUN;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
    end
  end
  sync_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(redirect_i),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .din_i  (rom_e),
    .dout_o (head_e),
    .count_o(count)
  );
  assign rom_addr_o = pc_q;
  assign count_o = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected dequeued entries and point checks
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic [63:0] rom_addr;
  logic [31:0] rom_data;
  logic rom_fault;
  logic redirect = 0;
  logic [63:0] redirect_pc = '0;
  logic halt = 1;
  logic deq_valid;
  logic deq_ready = 0;
  logic [63:0] deq_pc;
  logic [31:0] deq_inst;
  logic deq_fault;
  logic [2:0] count;
  logic [63:0] fault_addr = '1;
  int vectors = 0;
  int errors = 0;
  fetch_entry_t exp_q[$];
  always #5 clk = ~clk;
  assign rom_data = rom_addr[31:0] + 32'h13;
  assign rom_fault = rom_addr == fault_addr;
  fetch_queue dut (
    .clk_i(clk), .rst_i(rst), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .rom_fault_i(rom_fault), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .halt_i(halt), .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
    .deq_pc_o(deq_pc), .deq_inst_o(deq_inst), .deq_fault_o(deq_fault), .count_o(count)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_entry(input logic [63:0] pc, input logic f);
    fetch_entry_t e;
    e.pc = pc;
    e.inst = pc[31:0] + 32'h13;
    e.fault = f;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (!rst && deq_valid && deq_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL deq_unexpected: got pc=%h inst=%h fault=%b expected none", deq_pc, deq_inst, deq_fault);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        if (deq_pc !== e.pc || deq_inst !== e.inst || deq_fault !== e.fault) begin
          errors++;
          $display("FAIL deq_entry: got pc=%h inst=%h fault=%b expected pc=%h inst=%h fault=%b",
                   deq_pc, deq_inst, deq_fault, e.pc, e.inst, e.fault);
        end
      end
    end
  end
  initial begin
    step(2);
    check("rst_count", 64'(count), 0);
    check("rst_valid", 64'(deq_valid), 0);
    check("rst_deq_pc", deq_pc, 0);
    check("rst_deq_inst", 64'(deq_inst), 0);
    check("rst_rom_addr", rom_addr, 0);
    expect_entry(64'h0, 0);
    expect_entry(64'h4, 0);
    expect_entry(64'h8, 0);
    rst = 0; halt = 0; deq_ready = 1;
    step(2);
    check("stream_count_le1", 64'(count <= 1), 1);
    step(1);
    halt = 1;
    step(2);
    check("stream_count_end", 64'(count), 0);
    check("stream_rom_addr", rom_addr, 64'hC);
    redirect = 1; redirect_pc = 64'h0; halt = 0; deq_ready = 0;
    step(1);
    redirect = 0;
    step(10);
    check("stall_count", 64'(count), 4);
    check("stall_rom_addr", rom_addr, 64'h10);
    expect_entry(64'h0, 0);
    expect_entry(64'h4, 0);
    expect_entry(64'h8, 0);
    expect_entry(64'hC, 0);
    expect_entry(64'h10, 0);
    deq_ready = 1;
    step(1);
    check("full_pushpop_count", 64'(count), 4);
    halt = 1;
    step(4);
    check("drain_count", 64'(count), 0);
    check("drain_rom_addr", rom_addr, 64'h14);
    fault_addr = 64'h8;
    expect_entry(64'h0, 0);
    expect_entry(64'h4, 0);
    expect_entry(64'h8, 1);
    redirect = 1; redirect_pc = 64'h0; halt = 0;
    step(1);
    redirect = 0;
    step(6);
    check("fault_rom_addr", rom_addr, 64'hC);
    check("fault_count", 64'(count), 0);
    check("fault_valid", 64'(deq_valid), 0);
    fault_addr = '1;
    expect_entry(64'h100, 0);
    redirect = 1; redirect_pc = 64'h100;
    step(1);
    redirect = 0;
    step(1);
    halt = 1;
    step(2);
    check("refetch_rom_addr", rom_addr, 64'h104);
    check("refetch_count", 64'(count), 0);
    deq_ready = 0; halt = 0;
    step(3);
    halt = 1;
    check("three_count", 64'(count), 3);
    redirect = 1; redirect_pc = 64'h40; deq_ready = 1;
    #1;
    check("redirect_valid", 64'(deq_valid), 0);
    step(1);
    redirect = 0;
    check("flush_count", 64'(count), 0);
    check("flush_rom_addr", rom_addr, 64'h40);
    deq_ready = 0; halt = 0;
    step(2);
    halt = 1;
    check("halt_count", 64'(count), 2);
    check("halt_rom_addr", rom_addr, 64'h48);
    expect_entry(64'h40, 0);
    expect_entry(64'h44, 0);
    deq_ready = 1;
    step(2);
    check("halt_drain_count", 64'(count), 0);
    check("halt_held_addr", rom_addr, 64'h48);
    expect_entry(64'h48, 0);
    halt = 0;
    step(1);
    halt = 1;
    step(2);
    check("resume_rom_addr", rom_addr, 64'h4C);
    expect_entry(64'hFFFF_FFFF_FFFF_FFFC, 0);
    expect_entry(64'h0, 0);
    redirect = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; halt = 0;
    step(1);
    redirect = 0;
    step(2);
    halt = 1;
    step(2);
    check("wrap_rom_addr", rom_addr, 64'h4);
    check("wrap_count", 64'(count), 0);
    deq_ready = 0; halt = 0;
    step(3);
    check("pre_reset_count", 64'(count), 3);
    rst = 1;
    step(1);
    rst = 0; halt = 1;
    check("midrst_count", 64'(count), 0);
    check("midrst_valid", 64'(deq_valid), 0);
    check("midrst_rom_addr", rom_addr, 64'h0);
    step(2);
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupled instruction-fetch front end sitting directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the CodeROM address.
- Buffers {PC, instruction, fault} entries in a small FIFO and hands them to the decode side over a valid/ready handshake.
- Absorbs decode stalls, and is flushed and redirected on branch misprediction or trap.

Parameters:
- DATA_WIDTH, 64, PC/address width.
- INST_WIDTH, 32, instruction width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_PC, 64'h0, fetch PC loaded on reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset (synchronous, active-high).
- rom_addr_o  out  DATA_WIDTH  fetch address to CodeROM (combinational ROM).
- rom_data_i  in  INST_WIDTH  instruction word for rom_addr_o, same cycle.
- rom_fault_i  in  1  illegal access flag for rom_addr_o, same cycle.
- redirect_i  in  1  flush and restart fetch (mispredict/trap).
- redirect_pc_i  in  DATA_WIDTH  restart PC, valid with redirect_i.
- halt_i  in  1  suppress new fetches (ECALL/EBREAK drain); queue still drains.
- deq_valid_o  out  1  head entry valid.
- deq_ready_i  in  1  decode accepts head (low = pipeline stall).
- deq_pc_o  out  DATA_WIDTH  head PC.
- deq_inst_o  out  INST_WIDTH  head instruction.
- deq_fault_o  out  1  head entry fetch-faulted.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_i=1 at a posedge):
  - fetch_pc=RESET_PC, FIFO empty, count_o=0, state=RUN.
  - deq_valid_o=0; deq_pc_o, deq_inst_o and deq_fault_o read 0.
  - Reset mid-operation discards all entries and any FAULT state.
- rom_addr_o = fetch_pc register, no combinational path from other inputs.
- States:
  - RUN: fetching.
  - FAULT: a faulting entry has been queued; no further fetches.
- push = (state==RUN) & !halt_i & !redirect_i & (count<DEPTH | pop).
- pop = deq_valid_o & deq_ready_i & !redirect_i.
- On push:
  - Enqueue {fetch_pc, rom_data_i, rom_fault_i}.
  - fetch_pc <= fetch_pc+4, modulo 2^DATA_WIDTH (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
  - If rom_fault_i=1, state <= FAULT.
- Full with simultaneous pop: push allowed and count unchanged. Empty: deq_valid_o=0 and a pop is impossible.
- Simultaneous push+pop: count unchanged, entry order preserved (strict FIFO).
- Redirect has highest priority:
  - deq_valid_o forced 0 in the redirect cycle; no push, no pop.
  - Next cycle: FIFO empty, fetch_pc=redirect_pc_i, state=RUN.
  - Redirect while in FAULT also exits to RUN.
- Misaligned redirect_pc_i (bits[1:0]!=0) is not checked here; the ROM fault propagates as a faulted entry.
- halt_i=1: no push, fetch_pc held, pops proceed. Release resumes fetch at the held fetch_pc.
- Latency, without bypass: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest.
- Throughput: one entry per cycle sustained.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when FIFO empty, push occurs and deq_ready_i=1, the ROM word is presented on deq_* in the same cycle (deq_valid_o=1) and is not stored. count_o stays 0. fetch_pc still advances and the FAULT transition still applies. Zero-cycle fetch latency.
- Not defined: no combinational ROM-to-deq path; minimum latency 1 cycle.

Decomposition:
- Shared pipeline package:
  - typedef fetch_entry_t {pc, inst, fault}.
  - FETCH_QUEUE_DEPTH and RESET_PC constants.
  - Fetch state enum {FQ_RUN, FQ_FAULT}.
- Sub-module sync_fifo: generic entry-typed circular buffer with DEPTH, head/tail pointers, count, flush_i.
- fetch_queue wraps sync_fifo plus PC/state logic.

Test Plan:
- Reset release, ROM returns 0x00000013 everywhere, deq_ready_i=1 -> heads at PCs 0x0, 0x4, 0x8 on consecutive cycles starting cycle 1 after reset (cycle 0 with bypass); count_o<=1.
- deq_ready_i=0 for 10 cycles -> count_o reaches 4, rom_addr_o holds at 0x10. On release, heads 0x0..0xC in order, then 0x10, with no gap.
- rom_fault_i=1 at PC 0x8 -> entry 0x8 dequeued with deq_fault_o=1, rom_addr_o frozen at 0xC, no further entries. Then redirect_i with 0x100 -> next head PC 0x100 with fault=0.
- Queue holding 3 entries, redirect_i=1 with deq_ready_i=1 and redirect_pc_i=0x40 -> no pop that cycle, count_o=0 next cycle, rom_addr_o=0x40.
- halt_i=1 with 2 entries queued -> both drain, count_o=0, rom_addr_o unchanged. halt_i=0 -> fetch resumes at the held address.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC -> entries at 0x...FFFC then 0x0 (wrap). Reset asserted mid-stream -> next cycle count_o=0, deq_valid_o=0, rom_addr_o=RESET_PC.
